// File: rtl/alu_operand_loader.sv
// alu_operand_loader
// Operand entry stage feeding the ALU seven-segment decoder. A debounced push
// button steps through LOAD_A -> LOAD_B -> LOAD_OP -> SHOW, capturing the switch
// value into a, b or op on each press. All outputs come straight from flops.
module alu_operand_loader #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw,
    input  logic       btn_raw,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic       op,
    output logic [1:0] stage,
    output logic       valid
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ST_LOAD_A  = 2'd0;
    localparam logic [1:0] ST_LOAD_B  = 2'd1;
    localparam logic [1:0] ST_LOAD_OP = 2'd2;
    localparam logic [1:0] ST_SHOW    = 2'd3;

    // Button synchronizer and debounce state
    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q;
    logic          stable_d;
    logic          stable_dly_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          press_s;

    // Operand / FSM state
    logic [1:0]    stage_q;
    logic [1:0]    stage_d;
    logic [3:0]    a_q;
    logic [3:0]    a_d;
    logic [3:0]    b_q;
    logic [3:0]    b_d;
    logic          op_q;
    logic          op_d;
    logic          valid_q;
    logic          valid_d;

    // Two-flop synchronizer bringing the asynchronous button into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: the stable level only follows the synchronized button after it
    // has disagreed for DEBOUNCE_CYCLES consecutive cycles
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = sync2_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Debounce registers plus one-cycle delayed copy for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            cnt_q        <= cnt_d;
        end
    end

    // One-cycle press pulse on each 0->1 change of the debounced level
    assign press_s = stable_q & ~stable_dly_q;

    // Sequencer: each press captures the switch into the slot for the current
    // stage and advances; without a press everything holds
    always_comb begin
        stage_d = stage_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        if (press_s) begin
            case (stage_q)
                ST_LOAD_A: begin
                    a_d     = sw;
                    stage_d = ST_LOAD_B;
                end
                ST_LOAD_B: begin
                    b_d     = sw;
                    stage_d = ST_LOAD_OP;
                end
                ST_LOAD_OP: begin
                    op_d    = sw[0];
                    stage_d = ST_SHOW;
                end
                ST_SHOW: begin
                    stage_d = ST_LOAD_A;
                end
                default: begin
                    stage_d = ST_LOAD_A;
                end
            endcase
        end else begin
            stage_d = stage_q;
        end
        // valid is registered alongside stage so both change on the same edge
        valid_d = (stage_d == ST_SHOW);
    end

    // Operand, stage and valid registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= ST_LOAD_A;
            a_q     <= 4'd0;
            b_q     <= 4'd0;
            op_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            stage_q <= stage_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            valid_q <= valid_d;
        end
    end

    assign a     = a_q;
    assign b     = b_q;
    assign op    = op_q;
    assign stage = stage_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Testbench for alu_operand_loader with a short debounce window. A small
// reference model tracks which slot the next press fills and what each output
// should hold; directed steps exercise reset, sequencing, glitch rejection,
// exact latency, long holds with chatter, wrap from SHOW and mid-run reset.
module tb_alu_operand_loader;

    localparam int D = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] sw;
    logic       btn_raw;
    logic [3:0] a;
    logic [3:0] b;
    logic       op;
    logic [1:0] stage;
    logic       valid;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model: step index 0..3 and the three captured values
    int         m_stage;
    logic [3:0] m_slot [3];

    alu_operand_loader #(.DEBOUNCE_CYCLES(D)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sw      (sw),
        .btn_raw (btn_raw),
        .a       (a),
        .b       (b),
        .op      (op),
        .stage   (stage),
        .valid   (valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        m_stage   = 0;
        m_slot[0] = 4'd0;
        m_slot[1] = 4'd0;
        m_slot[2] = 4'd0;
    endtask

    task automatic model_press(input logic [3:0] v);
        if (m_stage < 3) begin
            m_slot[m_stage] = (m_stage == 2) ? {3'd0, v[0]} : v;
        end
        m_stage = (m_stage + 1) % 4;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".a"},     a,               m_slot[0]);
        chk({tag, ".b"},     b,               m_slot[1]);
        chk({tag, ".op"},    {3'd0, op},      m_slot[2]);
        chk({tag, ".stage"}, {2'd0, stage},   4'(m_stage));
        chk({tag, ".valid"}, {3'd0, valid},   (m_stage == 3) ? 4'd1 : 4'd0);
    endtask

    // Full press: hold well past the debounce window, then release and let the
    // release settle. The switch is scrambled after capture to show it is ignored.
    task automatic press(input logic [3:0] v);
        @(negedge clk);
        sw      = v;
        btn_raw = 1'b1;
        repeat (D + 4) @(negedge clk);
        sw      = 4'($urandom);
        btn_raw = 1'b0;
        repeat (D + 6) @(negedge clk);
        model_press(v);
    endtask

    task automatic goto_stage(input int s);
        for (int i = 0; i < 4 && m_stage != s; i++) begin
            press(4'($urandom));
        end
    endtask

    initial begin
        logic [3:0] old_a;
        logic [3:0] v;
        int         glen;

        rst_n   = 1'b1;
        sw      = 4'd0;
        btn_raw = 1'b0;
        model_reset();

        // 1. asynchronous reset before any clock edge
        #1 rst_n = 1'b0;
        #1 check_all("reset_noclk");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_all("after_reset");

        // 2. directed load sequence
        press(4'h5);
        press(4'hB);
        press(4'h1);
        check_all("seq_5B1");

        // randomized full cycles
        for (int r = 0; r < 6; r++) begin
            press(4'($urandom));
            check_all("rand_press");
        end

        // 3. glitches shorter than the debounce window are dropped
        for (int r = 0; r < 4; r++) begin
            glen = int'($urandom_range(1, D - 1));
            @(negedge clk);
            sw      = 4'($urandom);
            btn_raw = 1'b1;
            repeat (glen) @(negedge clk);
            btn_raw = 1'b0;
            repeat (D + 6) @(negedge clk);
            check_all("glitch");
        end

        // 4. exact capture latency in LOAD_A
        goto_stage(0);
        old_a = m_slot[0];
        if (old_a == 4'hC) begin
            press(4'h3);
            goto_stage(0);
            old_a = m_slot[0];
        end
        @(negedge clk);
        sw      = 4'hC;
        btn_raw = 1'b1;
        @(posedge clk);                 // edge k
        repeat (D + 1) @(posedge clk);  // edge k+D+1
        #1 chk("lat_before.a", a, old_a);
        chk("lat_before.stage", {2'd0, stage}, 4'd0);
        @(posedge clk);                 // edge k+D+2
        #1 chk("lat_at.a", a, 4'hC);
        chk("lat_at.stage", {2'd0, stage}, 4'd1);
        @(negedge clk);
        btn_raw = 1'b0;
        repeat (D + 6) @(negedge clk);
        model_press(4'hC);
        check_all("latency_done");

        // 5. long hold followed by chatter gives exactly one advance
        @(negedge clk);
        v       = 4'($urandom);
        sw      = v;
        btn_raw = 1'b1;
        repeat (50) @(negedge clk);
        for (int t = 0; t < 10; t++) begin
            btn_raw = ~btn_raw;
            @(negedge clk);
        end
        btn_raw = 1'b0;
        repeat (D + 6) @(negedge clk);
        model_press(v);
        check_all("hold_chatter");

        // 6. press in SHOW wraps to LOAD_A keeping operands
        goto_stage(3);
        check_all("in_show");
        press(4'($urandom));
        check_all("show_wrap");

        // 7. reset while in LOAD_OP with the debounce counter counting
        goto_stage(2);
        @(negedge clk);
        sw      = 4'($urandom);
        btn_raw = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        btn_raw  = 1'b0;
        model_reset();
        #1 check_all("mid_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_all("post_reset_idle");
        press(4'($urandom));
        check_all("post_reset_press");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
